// File: rtl/neuron_row_mac.sv
// Three-term signed MAC per row with ReLU-style clamp to an unsigned byte, over a 3-row pass.
// Latency: out_valid rises one cycle after the third operand transfer of a row.
// Backpressure: the result is held in OUTPUT until out_ready; in_ready is low outside ACCUM.
module neuron_row_mac #(
  parameter int SHIFT = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] weight,
  input  logic [7:0] activation,
  input  logic [1:0] row_index,
  input  logic       last_value,
  output logic       row_clear,
  output logic       increment,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_row,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic signed [17:0] acc;
  logic        [1:0]  col;
  logic signed [15:0] product;
  logic signed [17:0] acc_sum;
  logic signed [17:0] shifted;
  logic        [7:0]  act_val;
  logic               xfer;
  logic               hs;

  // 8x8 signed product; three of them cannot overflow an 18-bit accumulator.
  assign product = $signed(weight) * $signed(activation);
  assign acc_sum = acc + {{2{product[15]}}, product};
  assign shifted = acc_sum >>> SHIFT;

  // Activation: negative sums clamp to 0, large positive sums saturate at 255.
  always_comb begin
    act_val = shifted[7:0];
    if (acc_sum[17]) begin
      act_val = 8'd0;
    end else if (shifted[17:8] != 10'd0) begin
      act_val = 8'd255;
    end
  end

  // Next-state and combinational handshake outputs; all forced low while clear is held.
  always_comb begin
    state_nxt = state;
    row_clear = 1'b0;
    increment = 1'b0;
    in_ready  = 1'b0;
    xfer      = 1'b0;
    hs        = 1'b0;
    if (!clear) begin
      case (state)
        IDLE: begin
          if (start) begin
            row_clear = 1'b1;
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          in_ready = 1'b1;
          if (in_valid) begin
            xfer = 1'b1;
            if (col == 2'd2) begin
              state_nxt = OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            increment = 1'b1;
            hs        = 1'b1;
            state_nxt = last_value ? IDLE : ACCUM;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) && !clear;

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator, column counter and registered result/handshake flags.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      acc       <= 18'sd0;
      col       <= 2'd0;
      out_data  <= 8'd0;
      out_row   <= 2'd0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (row_clear) begin
        acc <= 18'sd0;
        col <= 2'd0;
      end
      if (xfer) begin
        acc <= acc_sum;
        col <= col + 2'd1;
        if (col == 2'd2) begin
          out_data  <= act_val;
          out_row   <= row_index;
          out_valid <= 1'b1;
        end
      end
      if (hs) begin
        out_valid <= 1'b0;
        acc       <= 18'sd0;
        col       <= 2'd0;
        done      <= last_value;
      end
    end
  end

endmodule

// File: tb/tb_neuron_row_mac.sv
// Bench for neuron_row_mac: randomized and directed rows checked against an arithmetic model.
// A small row counter model closes the row_clear/increment/row_index/last_value loop.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_neuron_row_mac;
  localparam int SHIFT = 4;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] weight = 8'd0;
  logic [7:0] activation = 8'd0;
  logic [1:0] row_index;
  logic       last_value;
  logic       row_clear;
  logic       increment;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_row;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int inc_count = 0;

  logic signed [7:0] pw [3][3];
  logic signed [7:0] pa [3][3];
  int                pstall [3];

  neuron_row_mac #(.SHIFT(SHIFT)) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .weight     (weight),
    .activation (activation),
    .row_index  (row_index),
    .last_value (last_value),
    .row_clear  (row_clear),
    .increment  (increment),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Downstream row index counter model.
  logic [1:0] row_cnt;
  always @(posedge clock or posedge clear) begin
    if (clear) row_cnt <= 2'd0;
    else if (row_clear) row_cnt <= 2'd0;
    else if (increment) row_cnt <= row_cnt + 2'd1;
  end
  assign row_index  = row_cnt;
  assign last_value = (row_cnt == 2'd2);

  always @(posedge clock) begin
    if (increment) inc_count <= inc_count + 1;
  end

  // Reference: sum of products, ReLU, scale by 2**SHIFT, saturate to a byte.
  function automatic int model(int r);
    int sum;
    sum = 0;
    for (int i = 0; i < 3; i++) sum += int'(pw[r][i]) * int'(pa[r][i]);
    if (sum < 0) return 0;
    sum = sum / (2 ** SHIFT);
    return (sum > 255) ? 255 : sum;
  endfunction

  task automatic run_row(input int r);
    int exp;
    exp = model(r);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      start = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; weight = pw[r][i]; activation = pa[r][i];
      #1;
      checks++;
      if ({busy, in_ready} !== 2'b11) begin
        errors++; $display("FAIL accum_ready row %0d xfer %0d: busy/in_ready=%b required 11", r, i, {busy, in_ready});
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL out_valid_early row %0d xfer %0d: got %b required 0", r, i, out_valid);
      end
      @(posedge clock);
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL latency row %0d: out_valid=%b required 1", r, out_valid);
    end
    checks++;
    if (out_data !== 8'(exp)) begin
      errors++; $display("FAIL out_data row %0d: got %0d required %0d", r, out_data, exp);
    end
    checks++;
    if (out_row !== 2'(r)) begin
      errors++; $display("FAIL out_row: got %0d required %0d", out_row, r);
    end
    for (int k = 0; k < pstall[r]; k++) begin
      // Stray start/in_valid while holding a result must have no effect.
      in_valid = 1'b1; weight = 8'($urandom); activation = 8'($urandom); start = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_data, out_row} !== {1'b1, 8'(exp), 2'(r)}) begin
        errors++; $display("FAIL hold row %0d cycle %0d: valid/data/row=%b/%0d/%0d required 1/%0d/%0d",
                           r, k, out_valid, out_data, out_row, exp, r);
      end
      checks++;
      if ({in_ready, increment, row_clear} !== 3'b000) begin
        errors++; $display("FAIL stall_ctrl row %0d cycle %0d: in_ready/increment/row_clear=%b required 000",
                           r, k, {in_ready, increment, row_clear});
      end
      @(negedge clock);
      start = 1'b0; in_valid = 1'b0;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (increment !== 1'b1) begin
      errors++; $display("FAIL increment_hs row %0d: got %b required 1", r, increment);
    end
    @(posedge clock);
  endtask

  // Starts a pass at the current falling edge (or the next one) and runs 3 rows.
  task automatic run_pass(input bit at_current_edge);
    int inc0;
    if (!at_current_edge) @(negedge clock);
    inc0 = inc_count;
    start = 1'b1;
    #1;
    checks++;
    if ({row_clear, busy} !== 2'b10) begin
      errors++; $display("FAIL start row_clear/busy=%b required 10", {row_clear, busy});
    end
    @(posedge clock);
    for (int r = 0; r < 3; r++) run_row(r);
    @(negedge clock);
    out_ready = 1'b0;
    #1;
    checks++;
    if ({done, busy, out_valid} !== 3'b100) begin
      errors++; $display("FAIL pass_end done/busy/out_valid=%b required 100", {done, busy, out_valid});
    end
    checks++;
    if (inc_count - inc0 !== 3) begin
      errors++; $display("FAIL inc_pulses: got %0d required 3", inc_count - inc0);
    end
  endtask

  task automatic check_quiet(input string name);
    @(negedge clock);
    #1;
    checks++;
    if ({done, busy, in_ready, out_valid} !== 4'b0000) begin
      errors++; $display("FAIL %s done/busy/in_ready/out_valid=%b required 0000", name,
                         {done, busy, in_ready, out_valid});
    end
  endtask

  task automatic set_row(input int r, input int w0, input int w1, input int w2,
                         input int a0, input int a1, input int a2, input int stall);
    pw[r][0] = 8'(w0); pw[r][1] = 8'(w1); pw[r][2] = 8'(w2);
    pa[r][0] = 8'(a0); pa[r][1] = 8'(a1); pa[r][2] = 8'(a2);
    pstall[r] = stall;
  endtask

  task automatic test_reset();
    start = 1'b1; in_valid = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_row, done} !== 12'd0) begin
      errors++; $display("FAIL reset_regs valid/data/row/done=%b/%0d/%0d/%b required 0", out_valid, out_data, out_row, done);
    end
    checks++;
    if ({in_ready, busy, increment, row_clear} !== 4'b0000) begin
      errors++; $display("FAIL reset_comb=%b required 0000", {in_ready, busy, increment, row_clear});
    end
    @(negedge clock);
    clear = 1'b0; start = 1'b0; in_valid = 1'b0;
    check_quiet("idle_after_reset");
  endtask

  task automatic test_full_pass();
    set_row(0, 16, 16, 16, 1, 2, 3, 0);        // sum 96 -> 6
    set_row(1, -10, -10, -10, 10, 10, 10, 1);  // sum -300 -> 0
    set_row(2, 127, 127, 127, 127, 127, 127, 5); // sum 48387 -> 255
    run_pass(1'b0);
    check_quiet("after_full_pass");
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 3; r++) begin
        set_row(r, int'($urandom), int'($urandom), int'($urandom),
                int'($urandom), int'($urandom), int'($urandom), int'($urandom_range(0, 3)));
      end
      run_pass(p != 0);
    end
    check_quiet("after_back_to_back");
  endtask

  task automatic test_reset_mid_accum();
    int inc0;
    set_row(0, 16, 16, 16, 1, 2, 3, 0);
    set_row(1, 16, 16, 16, 1, 2, 3, 1);
    set_row(2, 16, 16, 16, 1, 2, 3, 0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; in_valid = 1'b1; weight = 8'd100; activation = 8'd100;
    @(posedge clock);
    @(negedge clock);
    inc0 = inc_count;
    clear = 1'b1; start = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_row, done, in_ready, busy, increment, row_clear} !== 16'd0) begin
      errors++; $display("FAIL mid_reset valid/data/row/done=%b/%0d/%0d/%b comb=%b required all 0",
                         out_valid, out_data, out_row, done, {in_ready, busy, increment, row_clear});
    end
    @(negedge clock);
    clear = 1'b0; start = 1'b0; in_valid = 1'b0;
    check_quiet("idle_after_abort");
    checks++;
    if (inc_count !== inc0) begin
      errors++; $display("FAIL abort_increment: got %0d pulses required 0", inc_count - inc0);
    end
    run_pass(1'b0);
    check_quiet("after_recovery");
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_back_to_back();
    test_reset_mid_accum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_row_mac.md
NEURON_ROW_MAC -- requirements
Module: neuron_row_mac

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter SHIFT, default 4: arithmetic right-shift applied to the row sum before activation.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have clock, input, 1: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have clear, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have start, input, 1: begin a 3-row pass; sampled in IDLE only.
REQ-005 The block SHALL have in_valid/in_ready, input/output, 1 each: operand handshake; transfer when both are high.
REQ-006 The block SHALL have weight and activation, inputs, 8 each: signed two's-complement operands.
REQ-007 The block SHALL have row_index, input, 2, and last_value, input, 1: current row and last-row flag from the downstream row index counter.
REQ-008 The block SHALL have row_clear and increment, outputs, 1 each: drive the row index counter's clear and increment.
REQ-009 The block SHALL have out_valid/out_ready, output/input, 1 each: result handshake.
REQ-010 The block SHALL have out_data, output, 8: unsigned activated neuron value.
REQ-011 The block SHALL have out_row, output, 2: row_index captured with out_data.
REQ-012 The block SHALL have busy, output, 1 (state not IDLE), and done, output, 1 (one-cycle end-of-pass pulse).

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM and OUTPUT.
REQ-014 IDLE + start -> ACCUM; in that cycle the block SHALL assert row_clear (combinational), clear acc to 0 and clear col to 0.
REQ-015 In ACCUM the block SHALL hold in_ready=1; in all other states in_ready SHALL be 0.
REQ-016 On each ACCUM transfer the block SHALL update acc <= acc + weight*activation, using a 16-bit signed product and an 18-bit signed accumulator, with no overflow possible.
REQ-017 On each ACCUM transfer the block SHALL increment the 2-bit column counter col; the transfer with col==2 SHALL move the FSM to OUTPUT.
REQ-018 On entry to OUTPUT the block SHALL register out_data as: 0 if the final sum is negative; else 255 if (sum >>> SHIFT) > 255; else (sum >>> SHIFT)[7:0].
REQ-019 On entry to OUTPUT the block SHALL register out_row <= row_index.
REQ-020 out_valid SHALL rise the cycle after the third transfer, a latency of 1 cycle.
REQ-021 In OUTPUT, out_valid SHALL be 1 and out_data/out_row SHALL be held stable until out_ready=1.
REQ-022 In the OUTPUT handshake cycle the block SHALL assert increment=1 (combinational); increment SHALL be 0 in every other cycle.
REQ-023 On the OUTPUT handshake with last_value=0 the FSM SHALL go to ACCUM and clear acc and col.
REQ-024 On the OUTPUT handshake with last_value=1 the FSM SHALL go to IDLE, and done SHALL be 1 for exactly the next cycle.
REQ-025 The block SHALL ignore start outside IDLE, and SHALL ignore in_valid outside ACCUM (no acc change).
REQ-026 Back-to-back operation SHALL be supported: start high in the done cycle SHALL begin a new pass.

Reset
REQ-027 While clear=1, regardless of clock, the block SHALL force: state=IDLE, acc=0, col=0, out_data=0, out_row=0, out_valid=0, done=0.
REQ-028 While clear=1 the combinational outputs SHALL be in_ready=0, busy=0, increment=0, row_clear=0.
REQ-029 Assertion of clear mid-pass SHALL abort the pass with no increment pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-030 Scenario, nominal row: weight=16 with activations 1,2,3 (sum 96) -> out_data=6, out_valid exactly 1 cycle after the 3rd transfer, increment=1 in the handshake cycle.
REQ-031 Scenario, negative sum: weight=-10 with activation=10, three times (sum -300) -> out_data=0.
REQ-032 Scenario, saturation: weight=127 with activation=127, three times (sum 48387, shifted 3024) -> out_data=255.
REQ-033 Scenario, backpressure: out_ready held 0 for 5 cycles -> out_valid=1 and out_data/out_row stable; in_ready=0 and increment=0 throughout.
REQ-034 Scenario, full pass with a model row counter: three rows -> out_row sequence 0,1,2, three increment pulses, done pulse one cycle after the 3rd handshake, busy=0 afterwards.
REQ-035 Scenario, reset mid-ACCUM: clear asserted after 1 transfer -> all outputs 0 immediately; a subsequent start with weight=16 and activations 1,2,3 -> out_data=6, with no residue from the aborted pass.
